ram_port_responder: RTL and testbench



---
 rtl/ram_resp_pkg.sv | 26 ++
 rtl/ram_req_slot.sv | 69 ++++++
 rtl/ram_port_responder.sv | 164 ++++++++++++++++
 tb/tb_ram_port_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_resp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_resp_pkg : shared types for the two-port RAM responder
// Rev 1.0
// ---------------------------------------------------------------------------
package ram_resp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_t;

  localparam logic PORT1 = 1'b0;
  localparam logic PORT2 = 1'b1;

  localparam int SLOT_ADDR_W = 11;
  localparam int SLOT_DATA_W = 32;

  typedef struct packed {
    logic [SLOT_ADDR_W-1:0] addr;
    logic                   w_en;
    logic [SLOT_DATA_W-1:0] wdata;
  } slot_t;

endpackage
`default_nettype wire

// File: rtl/ram_req_slot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_req_slot : one-deep request holding slot with overrun detect
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_req_slot
  import ram_resp_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              pending,
  output logic              ready,
  output logic              overrun,
  output logic              slot_w_en,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_wdata
);

  logic              pending_q, pending_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // A request landing on the clearing edge refills the slot; it is still
  // flagged because the requester ignored ready.
  always_comb begin
    pending_d = pending_q & ~clr;
    w_en_d    = w_en_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (req && (!pending_q || clr)) begin
      pending_d = 1'b1;
      w_en_d    = w_en;
      addr_d    = addr;
      wdata_d   = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      w_en_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      w_en_q    <= w_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign pending    = pending_q;
  assign ready      = ~pending_q;
  assign overrun    = req & pending_q;
  assign slot_w_en  = w_en_q;
  assign slot_addr  = addr_q;
  assign slot_wdata = wdata_q;

endmodule
`default_nettype wire

// File: rtl/ram_port_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_port_responder : arbitrates fetch and data ports onto one sync RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_port_responder
  import ram_resp_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p1_req,
  input  logic              p1_w_en,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_valid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              p2_req,
  input  logic              p2_w_en,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_wdata,
  output logic              p2_ready,
  output logic              p2_valid,
  output logic [DATA_W-1:0] p2_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err_overrun
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic              s1_pending, s1_overrun, s1_w_en, clr1;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_wdata;
  logic              s2_pending, s2_overrun, s2_w_en, clr2;
  logic [ADDR_W-1:0] s2_addr;
  logic [DATA_W-1:0] s2_wdata;

  ram_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk(clk), .rst(rst), .req(p1_req), .w_en(p1_w_en), .addr(p1_addr),
    .wdata(p1_wdata), .clr(clr1), .pending(s1_pending), .ready(p1_ready),
    .overrun(s1_overrun), .slot_w_en(s1_w_en), .slot_addr(s1_addr),
    .slot_wdata(s1_wdata)
  );

  ram_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot2 (
    .clk(clk), .rst(rst), .req(p2_req), .w_en(p2_w_en), .addr(p2_addr),
    .wdata(p2_wdata), .clr(clr2), .pending(s2_pending), .ready(p2_ready),
    .overrun(s2_overrun), .slot_w_en(s2_w_en), .slot_addr(s2_addr),
    .slot_wdata(s2_wdata)
  );

  resp_state_t       state_q, state_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              p1_valid_q, p1_valid_d, p2_valid_q, p2_valid_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d, p2_rdata_q, p2_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_overrun_q, err_overrun_d;

  logic              win;
  logic              issue;
  logic              sel_w_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    if (s1_pending && s2_pending) begin
      win = (starve_cnt_q == STARVE_MAX) ? PORT1 : PORT2;
    end else begin
      win = s2_pending ? PORT2 : PORT1;
    end
    issue     = (state_q == IDLE) && (s1_pending || s2_pending);
    sel_w_en  = (win == PORT2) ? s2_w_en  : s1_w_en;
    sel_addr  = (win == PORT2) ? s2_addr  : s1_addr;
    sel_wdata = (win == PORT2) ? s2_wdata : s1_wdata;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    starve_cnt_d  = starve_cnt_q;
    p1_valid_d    = 1'b0;
    p2_valid_d    = 1'b0;
    p1_rdata_d    = p1_rdata_q;
    p2_rdata_d    = p2_rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    clr1          = 1'b0;
    clr2          = 1'b0;
    err_overrun_d = err_overrun_q | s1_overrun | s2_overrun;

    if (state_q == IDLE) begin
      if (issue) begin
        state_d     = WAIT;
        grant_d     = win;
        mem_addr_d  = sel_addr;
        mem_wdata_d = sel_wdata;
        starve_cnt_d = (win == PORT2 && s1_pending) ? starve_cnt_q + 1'b1 : '0;
      end else if (!s1_pending) begin
        starve_cnt_d = '0;
      end
    end else begin
      // RAM read data for the granted address is on mem_rdata this cycle.
      state_d = IDLE;
      if (grant_q == PORT1) begin
        clr1       = 1'b1;
        p1_valid_d = 1'b1;
        if (!s1_w_en) p1_rdata_d = mem_rdata;
      end else begin
        clr2       = 1'b1;
        p2_valid_d = 1'b1;
        if (!s2_w_en) p2_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= PORT1;
      starve_cnt_q  <= '0;
      p1_valid_q    <= 1'b0;
      p2_valid_q    <= 1'b0;
      p1_rdata_q    <= '0;
      p2_rdata_q    <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      starve_cnt_q  <= starve_cnt_d;
      p1_valid_q    <= p1_valid_d;
      p2_valid_q    <= p2_valid_d;
      p1_rdata_q    <= p1_rdata_d;
      p2_rdata_q    <= p2_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign mem_addr    = issue ? sel_addr  : mem_addr_q;
  assign mem_wdata   = issue ? sel_wdata : mem_wdata_q;
  assign mem_w_en    = issue & sel_w_en;
  assign p1_valid    = p1_valid_q;
  assign p2_valid    = p2_valid_q;
  assign p1_rdata    = p1_rdata_q;
  assign p2_rdata    = p2_rdata_q;
  assign busy        = (state_q != IDLE) | s1_pending | s2_pending;
  assign err_overrun = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ram_port_responder : directed bench with a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ram_port_responder;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              p1_req, p1_w_en, p2_req, p2_w_en;
  logic [ADDR_W-1:0] p1_addr, p2_addr;
  logic [DATA_W-1:0] p1_wdata, p2_wdata;
  logic              p1_ready, p1_valid, p2_ready, p2_valid;
  logic [DATA_W-1:0] p1_rdata, p2_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy, err_overrun;

  ram_port_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p1_req(p1_req), .p1_w_en(p1_w_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_valid(p1_valid), .p1_rdata(p1_rdata),
    .p2_req(p2_req), .p2_w_en(p2_w_en), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
    .p2_ready(p2_ready), .p2_valid(p2_valid), .p2_rdata(p2_rdata),
    .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Backing RAM: synchronous, one-cycle read latency.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_w_en) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: each port owns at most one outstanding request; the shared RAM
  // serves one request at a time, taking one issue cycle and one wait cycle.
  logic [DATA_W-1:0] mm [DEPTH];
  logic [1:0]        m_pend, m_wen, m_valid, m_clr;
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_wdata [2];
  logic [DATA_W-1:0] m_rdata [2];
  logic              m_active, m_err;
  int                m_gnt, m_cnt, m_w;
  logic [ADDR_W-1:0] m_last_addr;
  logic [DATA_W-1:0] m_last_wdata;
  logic              chk_en = 1'b0;

  function automatic int pick_winner();
    if (m_pend == 2'b11) return (m_cnt == LIMIT) ? 0 : 1;
    return m_pend[1] ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    m_valid = 2'b00;
    m_clr   = 2'b00;
    if (rst) begin
      m_pend = 2'b00; m_wen = 2'b00; m_active = 1'b0; m_err = 1'b0;
      m_gnt = 0; m_cnt = 0; m_last_addr = '0; m_last_wdata = '0;
      m_rdata[0] = '0; m_rdata[1] = '0;
    end else begin
      if (m_active) begin
        m_clr[m_gnt]   = 1'b1;
        m_valid[m_gnt] = 1'b1;
        if (!m_wen[m_gnt]) m_rdata[m_gnt] = mm[m_addr[m_gnt]];
        m_active = 1'b0;
      end else if (m_pend != 2'b00) begin
        m_w = pick_winner();
        if (m_wen[m_w]) mm[m_addr[m_w]] = m_wdata[m_w];
        m_last_addr  = m_addr[m_w];
        m_last_wdata = m_wdata[m_w];
        m_cnt    = (m_w == 1 && m_pend[0]) ? m_cnt + 1 : 0;
        m_gnt    = m_w;
        m_active = 1'b1;
      end else begin
        m_cnt = 0;
      end
      for (int p = 0; p < 2; p++) begin
        logic r;
        r = (p == 0) ? p1_req : p2_req;
        if (r && m_pend[p]) m_err = 1'b1;
        if (r && (!m_pend[p] || m_clr[p])) begin
          m_pend[p]  = 1'b1;
          m_wen[p]   = (p == 0) ? p1_w_en  : p2_w_en;
          m_addr[p]  = (p == 0) ? p1_addr  : p2_addr;
          m_wdata[p] = (p == 0) ? p1_wdata : p2_wdata;
        end else if (m_clr[p]) begin
          m_pend[p] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic              e_issue;
      int                e_w;
      e_issue = !m_active && (m_pend != 2'b00);
      e_w     = pick_winner();
      chk("p1_ready", p1_ready, !m_pend[0]);
      chk("p2_ready", p2_ready, !m_pend[1]);
      chk("p1_valid", p1_valid, m_valid[0]);
      chk("p2_valid", p2_valid, m_valid[1]);
      chk("p1_rdata", p1_rdata, m_rdata[0]);
      chk("p2_rdata", p2_rdata, m_rdata[1]);
      chk("busy", busy, m_active || (m_pend != 2'b00));
      chk("err_overrun", err_overrun, m_err);
      chk("mem_w_en", mem_w_en, e_issue && m_wen[e_w]);
      chk("mem_addr", mem_addr, e_issue ? m_addr[e_w] : m_last_addr);
      chk("mem_wdata", mem_wdata, e_issue ? m_wdata[e_w] : m_last_wdata);
    end
  end

  // Pre-edge event counters.
  int wen_cnt = 0, v1_cnt = 0;
  always @(posedge clk) begin
    if (!rst && mem_w_en) wen_cnt++;
    if (!rst && p1_valid) v1_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_p1(input logic req, input logic we, input int a, input logic [31:0] d);
    p1_req = req; p1_w_en = we; p1_addr = ADDR_W'(a); p1_wdata = d;
  endtask

  task automatic set_p2(input logic req, input logic we, input int a, input logic [31:0] d);
    p2_req = req; p2_w_en = we; p2_addr = ADDR_W'(a); p2_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_p1(0, 0, 0, '0);
    set_p2(0, 0, 0, '0);
    tick(2);
    chk_en = 1'b1;
    rst = 1'b0;
  endtask

  int base;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 32'hC0DE0000 ^ 32'(i);
      mm[i]  = 32'hC0DE0000 ^ 32'(i);
    end
    ram[16] = 32'hDEADBEEF; mm[16] = 32'hDEADBEEF;
    ram[1]  = 32'h11111111; mm[1]  = 32'h11111111;
    ram[2]  = 32'h22222222; mm[2]  = 32'h22222222;

    // Reset state and uncontested read latency.
    do_reset();
    chk("rst_p1_ready", p1_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    set_p1(1, 0, 'h010, '0);
    tick(); set_p1(0, 0, 0, '0);
    tick(2);
    chk("t1_p1_valid", p1_valid, 1'b1);
    chk("t1_p1_rdata", p1_rdata, 32'hDEADBEEF);
    tick();
    chk("t1_busy_idle", busy, 1'b0);

    // Port-2 write then read-back.
    do_reset();
    base = wen_cnt;
    set_p2(1, 1, 'h020, 32'h12345678);
    tick(); set_p2(0, 0, 0, '0);
    chk("t2_mem_w_en", mem_w_en, 1'b1);
    chk("t2_mem_addr", mem_addr, 11'h020);
    tick(2);
    chk("t2_wr_valid", p2_valid, 1'b1);
    set_p2(1, 0, 'h020, '0);
    tick(); set_p2(0, 0, 0, '0);
    tick(2);
    chk("t2_rd_valid", p2_valid, 1'b1);
    chk("t2_rd_data", p2_rdata, 32'h12345678);
    chk("t2_wen_pulses", wen_cnt - base, 1);

    // Simultaneous reads: port 2 first, port 1 two cycles later.
    do_reset();
    set_p1(1, 0, 'h001, '0);
    set_p2(1, 0, 'h002, '0);
    tick(); set_p1(0, 0, 0, '0); set_p2(0, 0, 0, '0);
    tick(2);
    chk("t3_p2_valid", p2_valid, 1'b1);
    chk("t3_p2_rdata", p2_rdata, 32'h22222222);
    chk("t3_p1_early", p1_valid, 1'b0);
    tick(2);
    chk("t3_p1_valid", p1_valid, 1'b1);
    chk("t3_p1_rdata", p1_rdata, 32'h11111111);

    // Starvation guard: port 2 refills its slot each time it clears.
    do_reset();
    set_p1(1, 0, 'h005, '0);
    set_p2(1, 0, 'h006, '0);
    tick(); set_p1(0, 0, 0, '0); set_p2(0, 0, 0, '0);
    chk("t4_arb1_addr", mem_addr, 11'h006);
    tick(); set_p2(1, 0, 'h007, '0);
    tick(); set_p2(0, 0, 0, '0);
    chk("t4_arb2_addr", mem_addr, 11'h007);
    tick(); set_p2(1, 0, 'h008, '0);
    tick(); set_p2(0, 0, 0, '0);
    chk("t4_arb3_addr", mem_addr, 11'h005);
    tick(2);
    chk("t4_p1_valid", p1_valid, 1'b1);
    chk("t4_p1_rdata", p1_rdata, 32'hC0DE0005);
    chk("t4_arb4_addr", mem_addr, 11'h008);
    tick(2);
    chk("t4_p2_rdata", p2_rdata, 32'hC0DE0008);

    // Overrun on back-to-back port-1 pulses.
    do_reset();
    base = v1_cnt;
    set_p1(1, 0, 'h010, '0);
    tick(2); set_p1(0, 0, 0, '0);
    chk("t5_err", err_overrun, 1'b1);
    tick(6);
    chk("t5_err_sticky", err_overrun, 1'b1);
    chk("t5_one_valid", v1_cnt - base, 1);

    // Reset during WAIT discards the port-2 read.
    do_reset();
    set_p2(1, 0, 'h030, '0);
    tick(); set_p2(0, 0, 0, '0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_p2_valid", p2_valid, 1'b0);
    chk("t6_p2_ready", p2_ready, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_mem_addr", mem_addr, 11'h000);
    chk("t6_p2_rdata", p2_rdata, 32'h0);
    set_p1(1, 0, 'h010, '0);
    tick(); set_p1(0, 0, 0, '0);
    tick(2);
    chk("t6_p1_valid", p1_valid, 1'b1);
    chk("t6_p1_rdata", p1_rdata, 32'hDEADBEEF);
    chk("t6_no_p2", p2_valid, 1'b0);
    tick(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
